// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: buffers writebacks in a small FIFO, sequences
// setup/pulse/hold strobes for writes and reads, and returns operands via valid/ready.
module regfile_access_ctrl #(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned SetupCycles = 1,
  parameter int unsigned PulseCycles = 1,
  parameter int unsigned WbDepth     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rd_req_valid_i,
  output logic                 rd_req_ready_o,
  input  logic                 rs1_en_i,
  input  logic                 rs2_en_i,
  input  logic [4:0]           rs1_addr_i,
  input  logic [4:0]           rs2_addr_i,
  output logic                 rd_rsp_valid_o,
  input  logic                 rd_rsp_ready_i,
  output logic [DataWidth-1:0] rs1_data_o,
  output logic [DataWidth-1:0] rs2_data_o,
  input  logic                 wb_valid_i,
  output logic                 wb_ready_o,
  input  logic [4:0]           wb_addr_i,
  input  logic                 wb_sel_alu_i,
  input  logic [DataWidth-1:0] wb_data_alu_i,
  input  logic [DataWidth-1:0] wb_data_lsu_i,
  output logic                 req_ra_o,
  output logic                 req_rb_o,
  output logic                 req_w_o,
  output logic [4:0]           raddr_a_o,
  output logic [4:0]           raddr_b_o,
  output logic [4:0]           waddr_a_o,
  output logic [DataWidth-1:0] wdata_alu_o,
  output logic [DataWidth-1:0] wdata_lsu_o,
  output logic                 soursel_o,
  input  logic [DataWidth-1:0] rdata_a_i,
  input  logic [DataWidth-1:0] rdata_b_i,
  output logic                 busy_o
);

  localparam int unsigned CntMax = (SetupCycles > PulseCycles) ? SetupCycles : PulseCycles;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned CountW = $clog2(WbDepth + 1);

  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_PULSE, R_CAPTURE, R_RESP
  } state_t;

  typedef struct packed {
    logic [4:0]           addr;
    logic                 sel;
    logic [DataWidth-1:0] alu;
    logic [DataWidth-1:0] lsu;
  } wb_entry_t;

  state_t              state, state_next;
  logic [CntW-1:0]     cnt, cnt_next;
  wb_entry_t           fifo [WbDepth];
  logic [CountW-1:0]   count, widx;
  logic                push, pop, accept, head_nz, second_nz;
  logic                ea, eb;
  logic [4:0]          ra_addr, rb_addr;
  logic [DataWidth-1:0] rs1_q, rs2_q;
  logic                req_ra_q, req_rb_q, req_w_q;
  logic                w_active, r_active;

  assign wb_ready_o     = !rst_i && (count < CountW'(WbDepth));
  assign push           = wb_valid_i && wb_ready_o;
  assign rd_req_ready_o = !rst_i && (state == IDLE) && (count == '0) && !wb_valid_i;
  assign accept         = rd_req_valid_i && rd_req_ready_o;
  assign head_nz        = (fifo[0].addr != '0);
  assign widx           = pop ? count - 1'b1 : count;

  // From W_HOLD only an already-buffered second entry can chain directly into W_SETUP.
  if (WbDepth > 1) begin : g_chain
    assign second_nz = (count > CountW'(1)) && (fifo[1].addr != '0);
  end else begin : g_nochain
    assign second_nz = 1'b0;
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (count != '0) begin
          if (!head_nz) pop = 1'b1;
          else          state_next = W_SETUP;
        end else if (accept) begin
          if ((rs1_en_i && rs1_addr_i != '0) || (rs2_en_i && rs2_addr_i != '0))
            state_next = R_SETUP;
          else
            state_next = R_RESP;
        end
      end
      W_SETUP, R_SETUP: begin
        if (cnt == CntW'(SetupCycles - 1)) begin
          state_next = (state == W_SETUP) ? W_PULSE : R_PULSE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      W_PULSE, R_PULSE: begin
        if (cnt == CntW'(PulseCycles - 1)) begin
          state_next = (state == W_PULSE) ? W_HOLD : R_CAPTURE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      W_HOLD: begin
        pop        = 1'b1;
        cnt_next   = '0;
        state_next = second_nz ? W_SETUP : IDLE;
      end
      R_CAPTURE: state_next = R_RESP;
      R_RESP:    if (rd_rsp_ready_i) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      req_w_q  <= 1'b0;
      req_ra_q <= 1'b0;
      req_rb_q <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      req_w_q  <= (state_next == W_PULSE);
      req_ra_q <= (state_next == R_PULSE) && ea;
      req_rb_q <= (state_next == R_PULSE) && eb;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
      for (int unsigned i = 0; i < WbDepth; i++) fifo[i] <= '0;
    end else begin
      if (pop)
        for (int unsigned i = 0; i + 1 < WbDepth; i++) fifo[i] <= fifo[i + 1];
      for (int unsigned i = 0; i < WbDepth; i++)
        if (push && widx == CountW'(i))
          fifo[i] <= '{addr: wb_addr_i, sel: wb_sel_alu_i, alu: wb_data_alu_i, lsu: wb_data_lsu_i};
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ea      <= 1'b0;
      eb      <= 1'b0;
      ra_addr <= '0;
      rb_addr <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      if (accept) begin
        ea      <= rs1_en_i && (rs1_addr_i != '0);
        eb      <= rs2_en_i && (rs2_addr_i != '0);
        ra_addr <= rs1_addr_i;
        rb_addr <= rs2_addr_i;
        rs1_q   <= '0;
        rs2_q   <= '0;
      end
      if (state == R_CAPTURE) begin
        rs1_q <= ea ? rdata_a_i : '0;
        rs2_q <= eb ? rdata_b_i : '0;
      end
    end
  end

  assign w_active = (state == W_SETUP) || (state == W_PULSE) || (state == W_HOLD);
  assign r_active = (state == R_SETUP) || (state == R_PULSE) || (state == R_CAPTURE);

  assign req_w_o        = req_w_q;
  assign req_ra_o       = req_ra_q;
  assign req_rb_o       = req_rb_q;
  assign waddr_a_o      = w_active ? fifo[0].addr : '0;
  assign wdata_alu_o    = w_active ? fifo[0].alu  : '0;
  assign wdata_lsu_o    = w_active ? fifo[0].lsu  : '0;
  assign soursel_o      = w_active ? fifo[0].sel  : 1'b0;
  assign raddr_a_o      = (r_active && ea) ? ra_addr : '0;
  assign raddr_b_o      = (r_active && eb) ? rb_addr : '0;
  assign rd_rsp_valid_o = (state == R_RESP);
  assign rs1_data_o     = rs1_q;
  assign rs2_data_o     = rs2_q;
  assign busy_o         = (state != IDLE) || (count != '0);

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Synchronous initiator that drives the edge-triggered register file (strobes req_ra/req_rb/req_w, addresses, write data, source select).
- Accepts operand-read requests from decode and writeback requests from ALU/LSU, and buffers writes in a small FIFO.
- Generates clean, clock-aligned strobe pulses with address/data setup and hold, and returns read operands through a valid/ready handshake.
- Enforces x0 semantics and read-after-write ordering, which the register file itself does not.

Parameters:
DataWidth, 32, operand/write data width
SetupCycles, 1, cycles (>=1) address/data are stable with strobe low before strobe rises
PulseCycles, 1, cycles (>=1) each strobe stays high
WbDepth, 2, writeback FIFO entries (>=1)

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-high reset
rd_req_valid_i  input  1  operand read request
rd_req_ready_o  output  1  read request accepted when both high at posedge
rs1_en_i  input  1  rs1 operand wanted
rs2_en_i  input  1  rs2 operand wanted
rs1_addr_i  input  5  rs1 index
rs2_addr_i  input  5  rs2 index
rd_rsp_valid_o  output  1  operands valid
rd_rsp_ready_i  input  1  consumer takes operands
rs1_data_o  output  DataWidth  rs1 value
rs2_data_o  output  DataWidth  rs2 value
wb_valid_i  input  1  writeback request
wb_ready_o  output  1  FIFO not full
wb_addr_i  input  5  destination index
wb_sel_alu_i  input  1  1 = ALU data, 0 = LSU data
wb_data_alu_i  input  DataWidth  ALU result
wb_data_lsu_i  input  DataWidth  load data
req_ra_o  output  1  register file read strobe, port A
req_rb_o  output  1  register file read strobe, port B
req_w_o  output  1  register file write strobe
raddr_a_o  output  5  port A address
raddr_b_o  output  5  port B address
waddr_a_o  output  5  write address
wdata_alu_o  output  DataWidth  write data (ALU)
wdata_lsu_o  output  DataWidth  write data (LSU)
soursel_o  output  1  write source select
rdata_a_i  input  DataWidth  port A data from register file
rdata_b_i  input  DataWidth  port B data from register file
busy_o  output  1  state != IDLE or FIFO non-empty

Behaviour:

Reset:
- rst_i high asynchronously forces state IDLE and empties the FIFO.
- All outputs go to 0, including strobes, addresses, data and rd_rsp_valid_o.
- Reset during a pulse drops the strobe immediately and discards the in-flight transfer.

Writeback FIFO:
- Push when wb_valid_i && wb_ready_o. wb_ready_o = count < WbDepth.
- Push and pop in the same cycle are allowed. A full FIFO with a same-cycle pop still reports wb_ready_o = 0.
- Order is preserved.

Priority and ordering:
- Writes have strict priority.
- rd_req_ready_o = (state == IDLE) && FIFO empty && !wb_valid_i. This guarantees read-after-write (RAW) ordering.

Write FSM (W_SETUP -> W_PULSE -> W_HOLD):
- IDLE with FIFO non-empty and head address == 0: pop in 1 cycle, no strobe, stay IDLE.
- IDLE with FIFO non-empty and head address != 0: go to W_SETUP.
- W_SETUP (SetupCycles): waddr_a_o, wdata_*_o and soursel_o are driven from the FIFO head; req_w_o = 0.
- W_PULSE (PulseCycles): req_w_o = 1.
- W_HOLD (1 cycle): req_w_o = 0, outputs held; pop at the end.
- From W_HOLD go to W_SETUP if the next head is non-zero, otherwise to IDLE.
- Write outputs are stable from W_SETUP entry through W_HOLD exit.
- The strobe is a flop output, glitch-free.

Read FSM (R_SETUP -> R_PULSE -> R_CAPTURE -> R_RESP):
- On accept, latch enables and addresses.
- Port A is effective when rs1_en_i && addr != 0; port B likewise for rs2.
- Neither port effective: go straight to R_RESP with zero data.
- R_SETUP (SetupCycles): raddr_a_o/raddr_b_o driven.
- R_PULSE (PulseCycles): req_ra_o/req_rb_o high only for effective ports.
- R_CAPTURE (1 cycle, strobes low): register rdata_a_i/rdata_b_i. A non-effective port returns 0.
- R_RESP: rd_rsp_valid_o = 1, data stable until rd_rsp_ready_i, then IDLE.
- Latency with defaults: accept cycle = 0, rd_rsp_valid_o high in cycle SetupCycles + PulseCycles + 2 = 4.

Constraints and outputs:
- At most one strobe family is active at a time; req_w_o is never high together with req_ra_o/req_rb_o.
- Read and write addresses return to 0 in IDLE.

Test Plan:
1. Push write x5 = 0xDEADBEEF with sel_alu = 1 -> req_w_o high exactly 1 cycle; waddr_a_o = 5, wdata_alu_o = 0xDEADBEEF and soursel_o = 1, stable from one cycle before to one cycle after the pulse; busy_o drops after W_HOLD.
2. Read rs1 = x5, rs2 = x0 (both enabled) after test 1 -> one req_ra_o pulse, no req_rb_o; rd_rsp_valid_o in cycle 4 with rs1 = 0xDEADBEEF, rs2 = 0.
3. Same-cycle write x7 = 0x12345678 (LSU, sel = 0) and read rs1 = x7 -> rd_req_ready_o stays low until the write strobe completes; response rs1 = 0x12345678, soursel_o = 0 during the write.
4. Three back-to-back writes (x1, x0, x2) with WbDepth = 2 -> wb_ready_o low after 2 pushes; the x0 entry pops with no req_w_o; exactly 2 write strobes, in order x1 then x2.
5. Read x5 with rd_rsp_ready_i held low 5 cycles -> rd_rsp_valid_o and rs1_data_o held constant, no further strobes, rd_req_ready_o low; returns to IDLE the cycle after ready.
6. Assert rst_i while req_w_o is high -> req_w_o falls without a clock edge, FIFO empty, wb_ready_o = 1 after reset release, all outputs 0.
